// File: rtl/hamming_seq_ctrl.sv
// Sequencing controller for a chunked Hamming-distance datapath: accumulates popcount(g ^ e)
// over CC chunks and publishes the distance with a done pulse. Optional macro: HAMMING_THRESH_EN.
module hamming_seq_ctrl #(
  parameter int N  = 32,
  parameter int CC = 4,
  localparam int M  = N / CC,
  localparam int OW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [M-1:0]  g_input,
  input  logic [M-1:0]  e_input,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] o
`ifdef HAMMING_THRESH_EN
  ,
  input  logic [OW-1:0] thresh,
  output logic          below
`endif
);

  localparam int CW = (CC > 1) ? $clog2(CC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [OW-1:0]   acc_r;
  logic [CW-1:0]   cnt_r;
  logic [OW-1:0]   o_r;
  logic [OW-1:0]   chunk_pop_s;
  logic [OW-1:0]   sum_s;
  logic            xfer_s;
  logic            last_s;

  function automatic logic [OW-1:0] popcount(input logic [M-1:0] v);
    logic [OW-1:0] cnt;
    cnt = {OW{1'b0}};
    for (int i = 0; i < M; i++) begin
      cnt = cnt + OW'(v[i]);
    end
    return cnt;
  endfunction

  assign in_ready    = (state_r == RUN);
  assign busy        = (state_r == RUN) || (state_r == DONE);
  assign done        = (state_r == DONE);
  assign o           = o_r;
  assign chunk_pop_s = popcount(g_input ^ e_input);
  assign sum_s       = acc_r + chunk_pop_s;
  assign xfer_s      = in_valid && in_ready;
  assign last_s      = (cnt_r == CW'(CC - 1));

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (xfer_s && last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

`ifdef HAMMING_THRESH_EN
  logic below_r;
  assign below = below_r;

  // Threshold flag, captured on the same edge as the final distance
  always_ff @(posedge clk) begin
    if (!rst) begin
      below_r <= 1'b0;
    end else if ((state_r == RUN) && xfer_s && last_s) begin
      below_r <= (sum_s <= thresh);
    end else begin
      below_r <= below_r;
    end
  end
`endif

  // State, accumulator, chunk counter and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      acc_r   <= {OW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      o_r     <= {OW{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r <= {OW{1'b0}};
            cnt_r <= {CW{1'b0}};
          end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
          end
        end
        RUN: begin
          if (xfer_s) begin
            acc_r <= sum_s;
            // The counter stops at CC-1 on the final chunk rather than wrapping
            if (last_s) begin
              o_r <= sum_s;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
          end
        end
        default: begin
          acc_r <= acc_r;
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Self-checking bench for hamming_seq_ctrl at N=8, CC=2: directed table, corner sequences,
// and randomized operations checked against an operand-level popcount model.
module tb_hamming_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [3:0] g_input;
  logic [3:0] e_input;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [3:0] o;
`ifdef HAMMING_THRESH_EN
  logic [3:0] thresh;
  logic       below;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hamming_seq_ctrl #(.N(8), .CC(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .g_input  (g_input),
    .e_input  (e_input),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .o        (o)
`ifdef HAMMING_THRESH_EN
    ,
    .thresh   (thresh),
    .below    (below)
`endif
  );

  typedef struct {
    logic [3:0] g0, e0, g1, e1;
    int         stall;
    logic [3:0] exp_o;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One operation from IDLE; returns in the DONE cycle after checking it
  task automatic run_op(input logic [3:0] g0, input logic [3:0] e0,
                        input logic [3:0] g1, input logic [3:0] e1,
                        input int stall, input logic [3:0] exp_o);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_in_ready", int'(in_ready), 1);
    check("run_busy", int'(busy), 1);
    in_valid = 1'b1; g_input = g0; e_input = e0;
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check("stall_done", int'(done), 0);
      check("stall_ready", int'(in_ready), 1);
      tick();
    end
    check("pre_last_done", int'(done), 0);
    in_valid = 1'b1; g_input = g1; e_input = e1;
    tick();
    in_valid = 1'b0;
    check("done_pulse", int'(done), 1);
    check("done_o", int'(o), int'(exp_o));
    check("done_ready", int'(in_ready), 0);
    check("done_busy", int'(busy), 1);
`ifdef HAMMING_THRESH_EN
    check("below", int'(below), int'(exp_o <= thresh));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ga, ea;
    logic [3:0] exp_o;
    int idx, cyc;

    vecs[0] = '{4'h9, 4'hB, 4'hA, 4'h7, 0, 4'd4};
    vecs[1] = '{4'hF, 4'hF, 4'hF, 4'hF, 0, 4'd0};
    vecs[2] = '{4'h0, 4'hF, 4'h0, 4'hF, 0, 4'd8};
    vecs[3] = '{4'h4, 4'hD, 4'h7, 4'h9, 3, 4'd5};

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; g_input = 4'h0; e_input = 4'h0;
`ifdef HAMMING_THRESH_EN
    thresh = 4'd4;
`endif
    tick(); tick();
    check("rst_o", int'(o), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(in_ready), 0);
    rst = 1'b1;
    tick();

    // Directed table, back-to-back: each start lands in the IDLE cycle after done
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].g0, vecs[i].e0, vecs[i].g1, vecs[i].e1, vecs[i].stall, vecs[i].exp_o);
      tick();
      check("idle_done", int'(done), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_hold_o", int'(o), int'(vecs[i].exp_o));
    end

`ifdef HAMMING_THRESH_EN
    thresh = 4'd3;
    run_op(4'h9, 4'hB, 4'hA, 4'h7, 0, 4'd4);
    tick();
    thresh = 4'd4;
`endif

    // Starts during RUN and DONE are ignored and not queued
    start = 1'b1;
    tick();
    in_valid = 1'b1; g_input = 4'h4; e_input = 4'hD;
    tick();
    in_valid = 1'b0;
    tick();
    check("ign_busy", int'(busy), 1);
    check("ign_done", int'(done), 0);
    in_valid = 1'b1; g_input = 4'h7; e_input = 4'h9;
    tick();
    in_valid = 1'b0;
    check("ign_done_pulse", int'(done), 1);
    check("ign_o", int'(o), 5);
    tick();
    start = 1'b0;
    check("ign_after_busy", int'(busy), 0);
    tick();
    check("ign_not_queued", int'(busy), 0);

    // Reset in the middle of an operation
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; g_input = 4'hF; e_input = 4'h0;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_o", int'(o), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(in_ready), 0);
    check("mid_rst_done", int'(done), 0);
    in_valid = 1'b1; g_input = 4'hF; e_input = 4'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("nostart_ready", int'(in_ready), 0);
      check("nostart_busy", int'(busy), 0);
    end
    in_valid = 1'b0;
    run_op(4'h9, 4'hB, 4'hA, 4'h7, 1, 4'd4);
    tick();

    // Randomized operations with random stalls and stray starts
    for (int n = 0; n < 60; n++) begin
      ga = 8'($urandom_range(0, 255));
      ea = 8'($urandom_range(0, 255));
      exp_o = 4'($countones(ga ^ ea));
`ifdef HAMMING_THRESH_EN
      thresh = 4'($urandom_range(0, 8));
`endif
      start = 1'b1;
      tick();
      idx = 0; cyc = 0;
      while (idx < 2 && cyc < 40) begin
        check("rnd_no_early_done", int'(done), 0);
        in_valid = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        g_input = (idx == 0) ? ga[3:0] : ga[7:4];
        e_input = (idx == 0) ? ea[3:0] : ea[7:4];
        tick();
        if (in_valid) idx++;
        cyc++;
      end
      in_valid = 1'b0;
      check("rnd_transfers", idx, 2);
      check("rnd_done", int'(done), 1);
      check("rnd_o", int'(o), int'(exp_o));
`ifdef HAMMING_THRESH_EN
      check("rnd_below", int'(below), int'(exp_o <= thresh));
`endif
      start = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      check("rnd_idle_busy", int'(busy), 0);
      check("rnd_hold_o", int'(o), int'(exp_o));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
